instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq_pkg.sv | 27 ++
 rtl/instr_seq_if.sv | 19 +
 rtl/instr_seq_mem_if.sv | 52 +++++
 rtl/instr_seq.sv | 147 ++++++++++++++
 tb/tb_instr_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, opcodes,
// parameter defaults and the branch offset helper.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StFault
  } state_e;

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [31:0] DefaultResetPc    = 32'h0000_0000;
  localparam int unsigned DefaultMemTimeout = 16;

  // Branch immediates are in halfwords: sign-extend {imm12, 0} to 32 bits.
  function automatic logic [31:0] branch_offset(logic [11:0] imm);
    return {{19{imm[11]}}, imm, 1'b0};
  endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Shared memory bus used for both instruction fetch and data access.
interface instr_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/instr_seq_mem_if.sv
// Request/hold/timeout handshake shared by fetch and data phases. Address and data come
// from registers so they stay stable for the whole request.
module seq_mem_if #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch,
  input  logic        data,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  instr_seq_if.master mem,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic            armed_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req;

  // armed_q keeps mem_req low until the first clock edge after reset release.
  assign req           = armed_q && (fetch || data);
  assign mem.mem_req   = req;
  assign mem.mem_we    = req && data && data_we;
  assign mem.mem_addr  = data ? data_addr : pc;
  assign mem.mem_wdata = data_wdata;

  assign done    = req && mem.mem_ready;
  assign timeout = req && !mem.mem_ready && (cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (req && !mem.mem_ready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback over a
// single shared memory port, with a sticky fault state left only through reset.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefaultResetPc,
  parameter int unsigned MEM_TIMEOUT = DefaultMemTimeout
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_seq_if.master mem,
  output logic [31:0] instr,
  input  logic        dec_rf_we,
  input  logic        dec_mem_we,
  input  logic        dec_is_load,
  input  logic        dec_branch,
  input  logic [11:0] imm12,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] rs2_data,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic        store_q, store_d;
  logic        load_q, load_d;
  logic        mem_done, mem_timeout;

  seq_mem_if #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_if (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (state_q == StFetch),
    .data      (state_q == StMem),
    .pc        (pc_q),
    .data_addr (addr_q),
    .data_wdata(wdata_q),
    .data_we   (store_q),
    .mem       (mem),
    .done      (mem_done),
    .timeout   (mem_timeout)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    store_d = store_q;
    load_d  = load_q;
    rf_we   = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_timeout) begin
          state_d = StFault;
        end else if (mem_done) begin
          instr_d = mem.mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!(dec_rf_we || dec_mem_we || dec_is_load || dec_branch)) begin
          state_d = StFault;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        load_d = dec_is_load;
        if (dec_branch) begin
          pc_d    = alu_zero ? pc_q + 32'd4 : pc_q + branch_offset(imm12);
          state_d = StFetch;
        end else if (dec_is_load || dec_mem_we) begin
          if (alu_result[1:0] != 2'b00) begin
            state_d = StFault;
          end else begin
            addr_d  = alu_result;
            wdata_d = rs2_data;
            store_d = dec_mem_we;
            state_d = StMem;
          end
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_timeout) begin
          state_d = StFault;
        end else if (mem_done) begin
          if (load_q) begin
            ldata_d = mem.mem_rdata;
            state_d = StWb;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = StFetch;
      end
      StFault: ;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      store_q <= store_d;
      load_q  <= load_d;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign fault    = (state_q == StFault);
  assign rf_wdata = load_q ? ldata_q : alu_result;

endmodule

// File: tb/tb_instr_seq.sv
// Randomized bench for instr_seq: the bench plays memory, decoder and ALU, and keeps an
// architectural model (pc, data memory, expected latency) to check each instruction.
module tb_instr_seq;
  import instr_seq_pkg::*;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int unsigned Tmo   = 16;
  localparam int KAddi = 0, KLw = 1, KSw = 2, KBne = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr, alu_result, rs2_data, rf_wdata, pc;
  logic        dec_rf_we, dec_mem_we, dec_is_load, dec_branch;
  logic [11:0] imm12;
  logic        alu_zero, rf_we, fault;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] exp_pc;
  logic [31:0] dmem [logic [31:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_seq_if bus ();

  instr_seq #(
    .RESET_PC   (RstPc),
    .MEM_TIMEOUT(Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .instr      (instr),
    .dec_rf_we  (dec_rf_we),
    .dec_mem_we (dec_mem_we),
    .dec_is_load(dec_is_load),
    .dec_branch (dec_branch),
    .imm12      (imm12),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rs2_data   (rs2_data),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .pc         (pc),
    .fault      (fault)
  );

  // Bench-side decoder: flags from the opcode, immediate from the top 12 bits.
  always_comb begin
    dec_rf_we   = (instr[6:0] == OpImm) || (instr[6:0] == OpLoad);
    dec_is_load = (instr[6:0] == OpLoad);
    dec_mem_we  = (instr[6:0] == OpStore);
    dec_branch  = (instr[6:0] == OpBranch);
    imm12       = instr[31:20];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_pc", pc, RstPc);
    check_eq("rst_instr", instr, 32'd0);
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("release_no_req", 32'(bus.mem_req), 32'd0);
    exp_pc = RstPc;
    @(negedge clk);
  endtask

  // Serves one fetch with fw wait cycles; called at a negedge, returns at a negedge.
  task automatic do_fetch(input logic [31:0] word, input int fw, output int t0);
    int k = 0;
    while (!bus.mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    check_eq("fetch_req", 32'(bus.mem_req), 32'd1);
    check_eq("fetch_pc", pc, exp_pc);
    for (int i = 0; i <= fw; i++) begin
      check_eq("fetch_addr", bus.mem_addr, exp_pc);
      check_eq("fetch_we", 32'(bus.mem_we), 32'd0);
      bus.mem_ready = (i == fw);
      bus.mem_rdata = (i == fw) ? word : $urandom;
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
  endtask

  task automatic run_instr(input int kind, input logic [11:0] imm, input logic [31:0] aluv,
                           input logic zero, input logic [31:0] rs2, input int fw,
                           input int dw);
    logic [6:0]  op;
    logic [31:0] word, nxt, rf_exp, ldata;
    int          lat, t0, rf_seen, dleft, d;
    bit          need_data, want_rf, is_st, done, found;
    op = (kind == KAddi) ? OpImm : (kind == KLw) ? OpLoad : (kind == KSw) ? OpStore : OpBranch;
    word       = {imm, 13'($urandom), op};
    alu_result = aluv;
    alu_zero   = zero;
    rs2_data   = rs2;
    nxt        = exp_pc + 32'd4;
    need_data  = 0;
    want_rf    = 0;
    is_st      = 0;
    rf_exp     = aluv;
    ldata      = '0;
    case (kind)
      KAddi: begin lat = 4; want_rf = 1; end
      KLw: begin
        lat = 5; want_rf = 1; need_data = 1;
        if (!dmem.exists(aluv)) dmem[aluv] = $urandom;
        ldata  = dmem[aluv];
        rf_exp = ldata;
      end
      KSw: begin lat = 4; need_data = 1; is_st = 1; dmem[aluv] = rs2; end
      default: begin
        lat = 3;
        if (!zero) nxt = exp_pc + 32'(int'($signed(imm)) * 2);
      end
    endcase
    d = need_data ? dw : 0;
    dleft = d;
    rf_seen = 0;
    done = !need_data;
    found = 0;
    do_fetch(word, fw, t0);
    for (int k = 0; k < 40; k++) begin
      if (rf_we) begin
        rf_seen++;
        check_eq("rf_wdata", rf_wdata, rf_exp);
      end
      if (bus.mem_req && !done) begin
        check_eq("data_addr", bus.mem_addr, aluv);
        check_eq("data_we", 32'(bus.mem_we), 32'(is_st));
        if (is_st) check_eq("data_wdata", bus.mem_wdata, rs2);
        if (dleft == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = ldata;
          done = 1;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          dleft--;
        end
      end else if (bus.mem_req) begin
        found = 1;
        break;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    check_eq("next_fetch_seen", 32'(found), 32'd1);
    check_eq("latency", 32'(cyc - t0), 32'(lat + fw + d));
    check_eq("rf_we_count", 32'(rf_seen), 32'(want_rf));
    exp_pc = nxt;
    check_eq("pc_after", pc, exp_pc);
  endtask

  initial begin
    int          n, t0, kind;
    logic [31:0] a;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    alu_result = '0;
    alu_zero = 1'b0;
    rs2_data = '0;
    exp_pc = RstPc;

    do_reset();

    // ADDI from pc 0 with zero wait, then walk up to 0x20 for the branch pair.
    for (int i = 0; i < 8; i++) run_instr(KAddi, 12'h0, 32'h1234_0000 + 32'(i), 1'b0, '0, 0, 0);
    run_instr(KBne, 12'hFFE, '0, 1'b0, '0, 0, 0);
    run_instr(KAddi, 12'h0, 32'h55, 1'b0, '0, 0, 0);
    run_instr(KBne, 12'hFFE, '0, 1'b1, '0, 0, 0);

    // Load with a 3-cycle data wait returning a known value.
    dmem[32'h0000_2000] = 32'hDEAD_BEEF;
    run_instr(KLw, 12'h0, 32'h0000_2000, 1'b0, '0, 0, 3);
    run_instr(KSw, 12'h0, 32'h0000_2004, 1'b0, 32'hCAFE_F00D, 0, 0);
    run_instr(KLw, 12'h0, 32'h0000_2004, 1'b0, '0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int fw, dw;
      kind = $urandom_range(0, 3);
      a = (kind == KLw || kind == KSw) ? 32'h1000 + 32'($urandom_range(0, 15) * 4) : $urandom;
      fw = ($urandom_range(0, 9) == 0) ? int'(Tmo) - 1 : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? int'(Tmo) - 1 : $urandom_range(0, 3);
      run_instr(kind, 12'($urandom), a, 1'($urandom), $urandom, fw, dw);
    end

    // Reset while a load waits in the data phase.
    alu_result = 32'h0000_3000;
    do_fetch({12'h0, 13'h0, OpLoad}, 0, t0);
    n = 0;
    while (!bus.mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_mem_req", 32'(bus.mem_req), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("mid_mem_hold", bus.mem_addr, 32'h0000_3000);
    do_reset();
    run_instr(KAddi, 12'h0, 32'h77, 1'b0, '0, 0, 0);

    // Misaligned store faults without touching memory; fault and pc stay put.
    alu_result = 32'h0000_0102;
    do_fetch({12'h0, 13'h0, OpStore}, 0, t0);
    for (int k = 0; k < 13; k++) begin
      check_eq("misalign_no_req", 32'(bus.mem_req), 32'd0);
      if (k >= 2) begin
        check_eq("misalign_fault", 32'(fault), 32'd1);
        check_eq("misalign_pc", pc, exp_pc);
      end
      @(negedge clk);
    end

    // Fetch never answered: fault after exactly Tmo requesting cycles.
    do_reset();
    n = 0;
    while (!bus.mem_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_cycles", 32'(n), 32'(Tmo));
    check_eq("timeout_fault", 32'(fault), 32'd1);
    check_eq("timeout_req", 32'(bus.mem_req), 32'd0);
    check_eq("timeout_pc", pc, RstPc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
